// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB page-table-walk AXI read master.
// Holds the walk FSM state encoding, the AXI4 read constants used on the
// AR channel and the per-requester ARPROT values.
package tlb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAr   = 2'd1,
      StR    = 2'd2,
      StResp = 2'd3
   } state_e;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [2:0] SIZE_8B     = 3'b011;
   localparam logic [7:0] LEN_1BEAT   = 8'd0;

   // Instruction fetches are privileged+instruction; data walks privileged only.
   localparam logic [2:0] PROT_ITLB   = 3'b101;
   localparam logic [2:0] PROT_DTLB   = 3'b001;

   // Only OKAY delivers a PTE; every other response is a bus error.
   function automatic logic resp_is_ok(input logic [1:0] resp);
      return resp == RESP_OKAY;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset (priority returns to input 0)
//   req_i  - request vector, bit 0 = ITLB, bit 1 = DTLB
//   en_i   - when high and a grant is issued, priority moves past the winner
//   gnt_o  - one-hot (or zero) combinational grant
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   // 0: input 0 wins a tie, 1: input 1 wins a tie.
   logic prio_q;

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
      end else if (en_i && (|gnt_o)) begin
         // Granting input 0 hands the next tie to input 1, and vice versa.
         prio_q <= gnt_o[0];
      end
   end

endmodule

// File: rtl/tlb_ptw_axim.sv
// Page-table-walk AXI4 read master shared by an ITLB and a DTLB.
// Each requester fires a one-cycle address pulse (no ready); the pulse is
// latched into a pending flag so nothing is lost while a walk is running.
// One single-beat 8-byte AXI read is outstanding at a time; the result is
// returned as a one-cycle DATA_VALID pulse (OKAY) or ACCESS_FAULT pulse.
// Ports:
//   CLK, RST                 - clock, synchronous active-high reset
//   ITLB_* / DTLB_*          - request pulse + PTE address in, PTE/fault pulses out
//   M_AXI_AR* / M_AXI_R*     - AXI4 read address and read data channels
module tlb_ptw_axim
   import tlb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 1
) (
   input  logic                  CLK,
   input  logic                  RST,

   input  logic                  ITLB_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] ITLB_ADDR,
   output logic                  ITLB_DATA_VALID,
   output logic [DATA_WIDTH-1:0] ITLB_DATA,
   output logic                  ITLB_ACCESS_FAULT,

   input  logic                  DTLB_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] DTLB_ADDR,
   output logic                  DTLB_DATA_VALID,
   output logic [DATA_WIDTH-1:0] DTLB_DATA,
   output logic                  DTLB_ACCESS_FAULT,

   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [ID_WIDTH-1:0]   M_AXI_ARID,
   output logic [7:0]            M_AXI_ARLEN,
   output logic [2:0]            M_AXI_ARSIZE,
   output logic [1:0]            M_AXI_ARBURST,
   output logic [2:0]            M_AXI_ARPROT,

   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RLAST,
   input  logic [ID_WIDTH-1:0]   M_AXI_RID
);

   // PTEs are 8-byte aligned; the low address bits are dropped on AR.
   localparam logic [ADDR_WIDTH-1:0] AddrAlignMask = ~ADDR_WIDTH'(7);

   state_e                state_q;
   logic                  sel_q;      // 0: ITLB walk, 1: DTLB walk
   logic                  arvalid_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [ID_WIDTH-1:0]   arid_q;
   logic [2:0]            arprot_q;
   logic                  rready_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;

   logic                  itlb_dv_q, itlb_af_q, dtlb_dv_q, dtlb_af_q;
   logic [DATA_WIDTH-1:0] itlb_data_q, dtlb_data_q;

   logic                  itlb_pend_q, itlb_pend_d;
   logic                  dtlb_pend_q, dtlb_pend_d;
   logic [ADDR_WIDTH-1:0] itlb_addr_q, itlb_addr_d;
   logic [ADDR_WIDTH-1:0] dtlb_addr_q, dtlb_addr_d;
   logic                  itlb_clr, dtlb_clr;

   logic [1:0]            arb_req;
   logic [1:0]            arb_gnt;
   logic                  arb_en;
   logic                  rbeat_ok;

   // ------------------------------------------------------------------
   // Request capture. A pending flag is cleared in RESP, but a pulse in
   // the same cycle re-arms it and loads the new address (set wins).
   // ------------------------------------------------------------------
   always_comb begin
      itlb_clr    = (state_q == StResp) && !sel_q;
      dtlb_clr    = (state_q == StResp) &&  sel_q;

      itlb_pend_d = ITLB_ADDR_VALID | (itlb_pend_q & ~itlb_clr);
      dtlb_pend_d = DTLB_ADDR_VALID | (dtlb_pend_q & ~dtlb_clr);

      itlb_addr_d = itlb_addr_q;
      if (ITLB_ADDR_VALID && (!itlb_pend_q || itlb_clr)) begin
         itlb_addr_d = ITLB_ADDR;
      end
      dtlb_addr_d = dtlb_addr_q;
      if (DTLB_ADDR_VALID && (!dtlb_pend_q || dtlb_clr)) begin
         dtlb_addr_d = DTLB_ADDR;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         itlb_pend_q <= 1'b0;
         dtlb_pend_q <= 1'b0;
         itlb_addr_q <= '0;
         dtlb_addr_q <= '0;
      end else begin
         itlb_pend_q <= itlb_pend_d;
         dtlb_pend_q <= dtlb_pend_d;
         itlb_addr_q <= itlb_addr_d;
         dtlb_addr_q <= dtlb_addr_d;
      end
   end

   // ------------------------------------------------------------------
   // Arbitration. An incoming pulse is visible to IDLE in its own cycle so
   // ARVALID can rise the very next cycle (4-cycle best-case latency).
   // ------------------------------------------------------------------
   assign arb_req = {dtlb_pend_q | DTLB_ADDR_VALID, itlb_pend_q | ITLB_ADDR_VALID};
   assign arb_en  = (state_q == StIdle);

   rr_arbiter2 u_arb (
      .clk_i (CLK),
      .rst_i (RST),
      .req_i (arb_req),
      .en_i  (arb_en),
      .gnt_o (arb_gnt)
   );

   // A beat that is not the last or carries a foreign ID is a bus error.
   assign rbeat_ok = M_AXI_RLAST && (M_AXI_RID == arid_q);

   // ------------------------------------------------------------------
   // Walk FSM with registered AXI controls and response pulses.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         sel_q       <= 1'b0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         arid_q      <= '0;
         arprot_q    <= PROT_ITLB;
         rready_q    <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= RESP_OKAY;
         itlb_dv_q   <= 1'b0;
         itlb_af_q   <= 1'b0;
         dtlb_dv_q   <= 1'b0;
         dtlb_af_q   <= 1'b0;
         itlb_data_q <= '0;
         dtlb_data_q <= '0;
      end else begin
         itlb_dv_q <= 1'b0;
         itlb_af_q <= 1'b0;
         dtlb_dv_q <= 1'b0;
         dtlb_af_q <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (|arb_gnt) begin
                  sel_q     <= arb_gnt[1];
                  arvalid_q <= 1'b1;
                  araddr_q  <= (arb_gnt[1] ? dtlb_addr_d : itlb_addr_d) & AddrAlignMask;
                  arid_q    <= arb_gnt[1] ? ID_WIDTH'(1) : ID_WIDTH'(0);
                  arprot_q  <= arb_gnt[1] ? PROT_DTLB : PROT_ITLB;
                  state_q   <= StAr;
               end
            end
            StAr: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= StR;
               end
            end
            StR: begin
               if (M_AXI_RVALID) begin
                  rready_q <= 1'b0;
                  rdata_q  <= M_AXI_RDATA;
                  rresp_q  <= rbeat_ok ? M_AXI_RRESP : RESP_SLVERR;
                  state_q  <= StResp;
               end
            end
            StResp: begin
               if (resp_is_ok(rresp_q)) begin
                  if (sel_q) begin
                     dtlb_dv_q   <= 1'b1;
                     dtlb_data_q <= rdata_q;
                  end else begin
                     itlb_dv_q   <= 1'b1;
                     itlb_data_q <= rdata_q;
                  end
               end else begin
                  // Faults leave the last delivered PTE untouched.
                  if (sel_q) begin
                     dtlb_af_q <= 1'b1;
                  end else begin
                     itlb_af_q <= 1'b1;
                  end
               end
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ITLB_DATA_VALID   = itlb_dv_q;
   assign ITLB_ACCESS_FAULT = itlb_af_q;
   assign ITLB_DATA         = itlb_data_q;
   assign DTLB_DATA_VALID   = dtlb_dv_q;
   assign DTLB_ACCESS_FAULT = dtlb_af_q;
   assign DTLB_DATA         = dtlb_data_q;

   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARID    = arid_q;
   assign M_AXI_ARLEN   = LEN_1BEAT;
   assign M_AXI_ARSIZE  = SIZE_8B;
   assign M_AXI_ARBURST = BURST_INCR;
   assign M_AXI_ARPROT  = arprot_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_tlb_ptw_axim.sv
// Directed self-checking bench for tlb_ptw_axim.
module tb_tlb_ptw_axim;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ITLB_ADDR_VALID, DTLB_ADDR_VALID;
   logic [63:0] ITLB_ADDR, DTLB_ADDR;
   logic        ITLB_DATA_VALID, DTLB_DATA_VALID;
   logic [63:0] ITLB_DATA, DTLB_DATA;
   logic        ITLB_ACCESS_FAULT, DTLB_ACCESS_FAULT;
   logic        M_AXI_ARVALID, M_AXI_ARREADY;
   logic [63:0] M_AXI_ARADDR;
   logic [0:0]  M_AXI_ARID;
   logic [7:0]  M_AXI_ARLEN;
   logic [2:0]  M_AXI_ARSIZE;
   logic [1:0]  M_AXI_ARBURST;
   logic [2:0]  M_AXI_ARPROT;
   logic        M_AXI_RVALID, M_AXI_RREADY;
   logic [63:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RLAST;
   logic [0:0]  M_AXI_RID;

   int n_checks = 0;
   int n_errors = 0;
   int pulse_cnt = 0;
   int excl_viol = 0;
   logic [63:0] last_data [2];
   logic        any_pulse;

   tlb_ptw_axim #(
      .ADDR_WIDTH (64),
      .DATA_WIDTH (64),
      .ID_WIDTH   (1)
   ) dut (
      .CLK               (CLK),
      .RST               (RST),
      .ITLB_ADDR_VALID   (ITLB_ADDR_VALID),
      .ITLB_ADDR         (ITLB_ADDR),
      .ITLB_DATA_VALID   (ITLB_DATA_VALID),
      .ITLB_DATA         (ITLB_DATA),
      .ITLB_ACCESS_FAULT (ITLB_ACCESS_FAULT),
      .DTLB_ADDR_VALID   (DTLB_ADDR_VALID),
      .DTLB_ADDR         (DTLB_ADDR),
      .DTLB_DATA_VALID   (DTLB_DATA_VALID),
      .DTLB_DATA         (DTLB_DATA),
      .DTLB_ACCESS_FAULT (DTLB_ACCESS_FAULT),
      .M_AXI_ARVALID     (M_AXI_ARVALID),
      .M_AXI_ARREADY     (M_AXI_ARREADY),
      .M_AXI_ARADDR      (M_AXI_ARADDR),
      .M_AXI_ARID        (M_AXI_ARID),
      .M_AXI_ARLEN       (M_AXI_ARLEN),
      .M_AXI_ARSIZE      (M_AXI_ARSIZE),
      .M_AXI_ARBURST     (M_AXI_ARBURST),
      .M_AXI_ARPROT      (M_AXI_ARPROT),
      .M_AXI_RVALID      (M_AXI_RVALID),
      .M_AXI_RREADY      (M_AXI_RREADY),
      .M_AXI_RDATA       (M_AXI_RDATA),
      .M_AXI_RRESP       (M_AXI_RRESP),
      .M_AXI_RLAST       (M_AXI_RLAST),
      .M_AXI_RID         (M_AXI_RID)
   );

   always #5 CLK = ~CLK;

   assign any_pulse = ITLB_DATA_VALID | ITLB_ACCESS_FAULT | DTLB_DATA_VALID | DTLB_ACCESS_FAULT;

   // Response pulses counted and checked for exclusivity away from the edge.
   always @(negedge CLK) begin
      int n;
      n = int'(ITLB_DATA_VALID) + int'(ITLB_ACCESS_FAULT)
        + int'(DTLB_DATA_VALID) + int'(DTLB_ACCESS_FAULT);
      pulse_cnt += n;
      if (n > 1) excl_viol++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse(input logic which, input logic [63:0] a);
      if (which) begin
         DTLB_ADDR_VALID = 1'b1; DTLB_ADDR = a;
      end else begin
         ITLB_ADDR_VALID = 1'b1; ITLB_ADDR = a;
      end
      tick();
      ITLB_ADDR_VALID = 1'b0;
      DTLB_ADDR_VALID = 1'b0;
   endtask

   // Acts as the AXI slave for one walk and checks the AR fields.
   task automatic serve(input string tag, input logic [63:0] exp_addr, input logic exp_id,
                        input logic [2:0] exp_prot, input logic [63:0] rdata,
                        input logic [1:0] rresp, input logic rlast, input logic rid);
      for (int i = 0; i < 20; i++) begin
         if (M_AXI_ARVALID) break;
         tick();
      end
      check_eq({tag, "_arvalid"}, M_AXI_ARVALID, 1);
      check_eq({tag, "_araddr"}, M_AXI_ARADDR, exp_addr);
      check_eq({tag, "_arid"}, M_AXI_ARID, exp_id);
      check_eq({tag, "_arprot"}, M_AXI_ARPROT, exp_prot);
      check_eq({tag, "_arfix"}, {M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}, {8'd0, 3'd3, 2'd1});
      M_AXI_ARREADY = 1'b1;
      tick();
      M_AXI_ARREADY = 1'b0;
      check_eq({tag, "_rready"}, M_AXI_RREADY, 1);
      M_AXI_RVALID = 1'b1; M_AXI_RDATA = rdata; M_AXI_RRESP = rresp;
      M_AXI_RLAST = rlast; M_AXI_RID = rid;
      tick();
      M_AXI_RVALID = 1'b0;
   endtask

   task automatic expect_resp(input string tag, input logic which, input logic ok,
                              input logic [63:0] data);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (any_pulse) break;
      end
      check_eq({tag, "_seen"}, any_pulse, 1);
      check_eq({tag, "_i_dv"}, ITLB_DATA_VALID, !which && ok);
      check_eq({tag, "_i_af"}, ITLB_ACCESS_FAULT, !which && !ok);
      check_eq({tag, "_d_dv"}, DTLB_DATA_VALID, which && ok);
      check_eq({tag, "_d_af"}, DTLB_ACCESS_FAULT, which && !ok);
      if (ok) last_data[which] = data;
      check_eq({tag, "_i_data"}, ITLB_DATA, last_data[0]);
      check_eq({tag, "_d_data"}, DTLB_DATA, last_data[1]);
      tick();
      check_eq({tag, "_one_cycle"}, any_pulse, 0);
   endtask

   initial begin
      int snap;
      RST = 1'b1;
      ITLB_ADDR_VALID = 0; DTLB_ADDR_VALID = 0; ITLB_ADDR = '0; DTLB_ADDR = '0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0;
      M_AXI_RLAST = 0; M_AXI_RID = 0;
      last_data[0] = '0; last_data[1] = '0;
      repeat (3) tick();
      RST = 1'b0;
      tick();

      // Reset state
      check_eq("rst_arvalid", M_AXI_ARVALID, 0);
      check_eq("rst_rready", M_AXI_RREADY, 0);
      check_eq("rst_pulses", any_pulse, 0);
      check_eq("rst_i_data", ITLB_DATA, 0);
      check_eq("rst_d_data", DTLB_DATA, 0);

      // Simultaneous pulses after reset: ITLB first, then DTLB
      ITLB_ADDR_VALID = 1; ITLB_ADDR = 64'h8000_3000;
      DTLB_ADDR_VALID = 1; DTLB_ADDR = 64'h8000_4010;
      tick();
      ITLB_ADDR_VALID = 0; DTLB_ADDR_VALID = 0;
      serve("tie0_i", 64'h8000_3000, 0, 3'b101, 64'h1111_0001, 2'b00, 1, 0);
      expect_resp("tie0_i", 0, 1, 64'h1111_0001);
      serve("tie0_d", 64'h8000_4010, 1, 3'b001, 64'h2222_0002, 2'b00, 1, 1);
      expect_resp("tie0_d", 1, 1, 64'h2222_0002);

      // Best-case latency: pulse in cycle 0, DATA_VALID in cycle 4
      M_AXI_ARREADY = 1; ITLB_ADDR = 64'h0000_0000_8000_1008; ITLB_ADDR_VALID = 1;
      tick();
      ITLB_ADDR_VALID = 0;
      check_eq("lat_arvalid_c1", M_AXI_ARVALID, 1);
      check_eq("lat_araddr", M_AXI_ARADDR, 64'h8000_1008);
      check_eq("lat_arprot", M_AXI_ARPROT, 3'b101);
      check_eq("lat_arid", M_AXI_ARID, 0);
      tick();
      M_AXI_ARREADY = 0;
      check_eq("lat_rready_c2", M_AXI_RREADY, 1);
      check_eq("lat_arvalid_c2", M_AXI_ARVALID, 0);
      M_AXI_RVALID = 1; M_AXI_RDATA = 64'h2000_0C01; M_AXI_RRESP = 0; M_AXI_RLAST = 1;
      M_AXI_RID = 0;
      tick();
      M_AXI_RVALID = 0;
      check_eq("lat_dv_c3", ITLB_DATA_VALID, 0);
      tick();
      check_eq("lat_dv_c4", ITLB_DATA_VALID, 1);
      check_eq("lat_data_c4", ITLB_DATA, 64'h2000_0C01);
      last_data[0] = 64'h2000_0C01;
      tick();
      check_eq("lat_dv_c5", ITLB_DATA_VALID, 0);
      check_eq("lat_hold_c5", ITLB_DATA, 64'h2000_0C01);

      // Tie after an ITLB grant goes to DTLB
      ITLB_ADDR_VALID = 1; ITLB_ADDR = 64'h8000_5000;
      DTLB_ADDR_VALID = 1; DTLB_ADDR = 64'h8000_6008;
      tick();
      ITLB_ADDR_VALID = 0; DTLB_ADDR_VALID = 0;
      serve("rr_d", 64'h8000_6008, 1, 3'b001, 64'h3333_0003, 2'b00, 1, 1);
      expect_resp("rr_d", 1, 1, 64'h3333_0003);
      serve("rr_i", 64'h8000_5000, 0, 3'b101, 64'h4444_0004, 2'b00, 1, 0);
      expect_resp("rr_i", 0, 1, 64'h4444_0004);

      // Misaligned DTLB address and SLVERR
      pulse(1, 64'h8000_2003);
      serve("slverr", 64'h8000_2000, 1, 3'b001, 64'hDEAD_BEEF, 2'b10, 1, 1);
      expect_resp("slverr", 1, 0, 64'h0);

      // Wrong RID is a fault
      pulse(0, 64'h8000_7000);
      serve("badrid", 64'h8000_7000, 0, 3'b101, 64'h5555_0005, 2'b00, 1, 1);
      expect_resp("badrid", 0, 0, 64'h0);

      // RLAST low is a fault
      pulse(1, 64'h8000_8000);
      serve("norlast", 64'h8000_8000, 1, 3'b001, 64'h6666_0006, 2'b00, 0, 1);
      expect_resp("norlast", 1, 0, 64'h0);

      // ARREADY stall of 5 cycles with a DTLB pulse arriving mid-stall
      pulse(0, 64'h8000_9000);
      for (int i = 0; i < 5; i++) begin
         check_eq("stall_arvalid", M_AXI_ARVALID, 1);
         check_eq("stall_araddr", M_AXI_ARADDR, 64'h8000_9000);
         if (i == 1) begin
            DTLB_ADDR_VALID = 1; DTLB_ADDR = 64'h8000_A000;
         end
         tick();
         DTLB_ADDR_VALID = 0;
      end
      serve("stall_i", 64'h8000_9000, 0, 3'b101, 64'h7777_0007, 2'b00, 1, 0);
      expect_resp("stall_i", 0, 1, 64'h7777_0007);
      serve("stall_d", 64'h8000_A000, 1, 3'b001, 64'h8888_0008, 2'b00, 1, 1);
      expect_resp("stall_d", 1, 1, 64'h8888_0008);

      // Reset while in R: walk abandoned, late beat ignored
      pulse(0, 64'h8000_B000);
      M_AXI_ARREADY = 1;
      tick();
      M_AXI_ARREADY = 0;
      check_eq("mid_rready", M_AXI_RREADY, 1);
      snap = pulse_cnt;
      RST = 1;
      tick();
      RST = 0;
      check_eq("mid_rst_rready", M_AXI_RREADY, 0);
      check_eq("mid_rst_arvalid", M_AXI_ARVALID, 0);
      check_eq("mid_rst_i_data", ITLB_DATA, 0);
      M_AXI_RVALID = 1; M_AXI_RDATA = 64'h9999_0009; M_AXI_RRESP = 0; M_AXI_RLAST = 1;
      M_AXI_RID = 0;
      tick();
      tick();
      M_AXI_RVALID = 0;
      for (int i = 0; i < 4; i++) begin
         check_eq("mid_no_ar", M_AXI_ARVALID, 0);
         tick();
      end
      check_eq("mid_no_resp", 64'(pulse_cnt - snap), 0);

      check_eq("pulse_exclusive", 64'(excl_viol), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tlb_ptw_axim.md
TLB_PTW_AXIM -- requirements
Module: tlb_ptw_axim

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, AXI/PTE address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, PTE/AXI read-data width.
REQ-003 SHALL have parameter ID_WIDTH, default 1, AXI ARID/RID width.
REQ-004 SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous reset, active-high.
REQ-005 SHALL have ITLB walk-request ports:
- ITLB_ADDR_VALID  in  1  one-cycle request pulse.
- ITLB_ADDR  in  ADDR_WIDTH  PTE address.
- ITLB_DATA_VALID  out  1  one-cycle response pulse.
- ITLB_DATA  out  DATA_WIDTH  PTE.
- ITLB_ACCESS_FAULT  out  1  one-cycle bus-error pulse.
REQ-006 SHALL have DTLB walk-request ports DTLB_ADDR_VALID, DTLB_ADDR, DTLB_DATA_VALID, DTLB_DATA and DTLB_ACCESS_FAULT, identical to REQ-005.
REQ-007 SHALL have AXI4 read-master ports:
- M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARID out ID_WIDTH.
- M_AXI_ARLEN out 8; M_AXI_ARSIZE out 3; M_AXI_ARBURST out 2; M_AXI_ARPROT out 3.
- M_AXI_RVALID in 1; M_AXI_RREADY out 1; M_AXI_RDATA in DATA_WIDTH; M_AXI_RRESP in 2; M_AXI_RLAST in 1; M_AXI_RID in ID_WIDTH.

Function
REQ-008 SHALL capture each request pulse into a per-requester pending flag and address register in the same edge; requesters have no ready signal, so no pulse may be lost, including pulses arriving during an active walk.
REQ-009 SHALL ignore a request pulse from a requester whose pending flag is already set, keeping the first address.
REQ-010 SHALL run FSM IDLE -> AR -> R -> RESP -> IDLE with one outstanding AXI transaction.
REQ-011 IDLE: if any flag is pending, SHALL grant one requester and go to AR next cycle; ARVALID is first high the cycle after the request pulse at the earliest.
REQ-012 Arbitration SHALL be round-robin: ITLB wins the first tie after reset, and a tie always goes to the requester not granted last.
REQ-013 AR: SHALL hold ARVALID and all AR fields stable until ARVALID&ARREADY, then go to R.
REQ-014 AR fields: ARADDR = granted address with bits [2:0] forced to 0; ARLEN=0; ARSIZE=3; ARBURST=INCR(1); ARID=0 for ITLB, 1 for DTLB; ARPROT=3'b101 for ITLB, 3'b001 for DTLB.
REQ-015 R: SHALL drive RREADY high only in R and capture RDATA/RRESP on RVALID&RREADY, then go to RESP.
REQ-016 R: a beat with RLAST=0 or RID != ARID SHALL be treated as RRESP error.
REQ-017 RESP: for RRESP=OKAY, SHALL pulse the granted requester's DATA_VALID for exactly one cycle with the captured data; for SLVERR/DECERR, SHALL pulse ACCESS_FAULT instead and leave DATA_VALID low.
REQ-018 RESP: SHALL clear the granted pending flag; a new pulse from that requester in the same cycle SHALL set the flag again (set wins).
REQ-019 *_DATA SHALL hold the last delivered PTE between pulses; DATA_VALID and ACCESS_FAULT SHALL never be high together or on both requesters in one cycle.
REQ-020 Best-case latency, request pulse to DATA_VALID with ARREADY and RVALID same-cycle-ready: 4 cycles.

Reset
REQ-021 RST SHALL clear FSM to IDLE, both pending flags, ARVALID, RREADY, all DATA_VALID/ACCESS_FAULT outputs, *_DATA to 0 and the round-robin pointer to ITLB.
REQ-022 RST mid-walk SHALL abandon the transaction without issuing a response; a late R beat after reset, arriving with RREADY low, SHALL be ignored.

Structure
REQ-023 FSM state encodings, AXI constants (BURST_INCR, RESP_OKAY, SIZE_8B) and the PROT values SHALL be in shared package tlb_pkg.
REQ-024 SHALL instantiate one sub-module, rr_arbiter2: 2-input round-robin arbiter with grant-update enable.

Verification
REQ-025 ITLB pulse with addr 0x0000_0000_8000_1008, ARREADY=1, RVALID next cycle with data 0x20000C01, OKAY -> ARADDR 0x80001008, ARPROT 3'b101, ITLB_DATA_VALID 4 cycles after pulse, data 0x20000C01.
REQ-026 ITLB and DTLB pulses in the same cycle -> ITLB served first (ARID 0), DTLB second (ARID 1), with no lost request.
REQ-027 DTLB pulse with addr 0x80002003 -> ARADDR 0x80002000; RRESP=SLVERR -> DTLB_ACCESS_FAULT single pulse, DTLB_DATA_VALID stays 0.
REQ-028 ARREADY held low 5 cycles -> ARVALID/ARADDR stable all 5 cycles; DTLB pulse during the stall is served after the ITLB walk.
REQ-029 RST asserted while in R -> next cycle: IDLE, RREADY=0, flags clear; subsequent RVALID produces no response pulse.
